// File: rtl/interrupt_sequencer_pkg.sv
// Shared processor definitions used by the interrupt sequencer and the
// control unit: sequencer state encodings and the interrupt/RTI micro-op
// opcodes that the control unit decodes.
package interrupt_sequencer_pkg;

  // Sequencer states, 3-bit encoding shared with the control unit.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_PUSH   = 3'd2,
    ST_VECTOR = 3'd3,
    ST_LOAD   = 3'd4
  } int_state_e;

  // Micro-op opcodes: forced push-PC/branch on interrupt, and return.
  localparam logic [5:0] OP_INT = 6'h3E;
  localparam logic [5:0] OP_RTI = 6'h3F;

endpackage : interrupt_sequencer_pkg

// File: rtl/interrupt_sequencer_pending_latch.sv
// int_pending_latch: holds the interrupt pending flag and the interrupt mask.
//   clk, rst_n     clock / async active-low reset
//   int_req_i      sets pending on the next edge (in any sequencer state)
//   clr_pending_i  clears pending (asserted by the sequencer in LOAD)
//   set_mask_i     sets mask (asserted on entry to DRAIN)
//   rti_done_i     clears mask
//   pending_o      registered pending flag
//   mask_o         effective mask: registered mask, already released in
//                  the cycle rti_done_i is high
module int_pending_latch
  import interrupt_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic int_req_i,
  input  logic clr_pending_i,
  input  logic set_mask_i,
  input  logic rti_done_i,
  output logic pending_o,
  output logic mask_o
);

  logic pending_q;
  logic mask_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      mask_q    <= 1'b0;
    end else begin
      // A new request wins over the LOAD clear so it is never dropped.
      if (int_req_i)          pending_q <= 1'b1;
      else if (clr_pending_i) pending_q <= 1'b0;
      // Entry into a new service re-masks even if an RTI lands that cycle.
      if (set_mask_i)         mask_q <= 1'b1;
      else if (rti_done_i)    mask_q <= 1'b0;
    end
  end

  assign pending_o = pending_q;
  // Pass rti_done straight through so a waiting request enters DRAIN in the
  // cycle right after the return completes.
  assign mask_o    = mask_q & ~rti_done_i;

endmodule : int_pending_latch

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: sequences an external interrupt into the pipeline:
// drain the pipe, push the PC, fetch the vector word, load the PC.
//   clk, rst_n    clock / async active-low reset
//   int_req       single-cycle interrupt request pulse
//   branch_busy   control transfer in flight; blocks acceptance in IDLE only
//   rti_done      return-from-interrupt completed (unmasks)
//   mem_ready     vector data valid on mem_rdata
//   mem_rdata     vector word
//   stall_fetch   hold PC and IF/ID       flush_decode  bubble into ID/EX
//   interrupt     push-PC/branch micro-op vec_rd/vec_addr vector read
//   load_pc       PC load strobe          new_pc        PC value to load
//   int_ack       interrupt accepted      busy          state != IDLE
// All outputs are registered, decoded from the next state.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int                DRAIN_CYCLES = 3,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] VEC_ADDR     = 'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_req,
  input  logic              branch_busy,
  input  logic              rti_done,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              flush_decode,
  output logic              interrupt,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              load_pc,
  output logic [ADDR_W-1:0] new_pc,
  output logic              int_ack,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  int_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] new_pc_d;
  logic              pending, mask, enter_drain;

  int_pending_latch u_latch (
    .clk           (clk),
    .rst_n         (rst_n),
    .int_req_i     (int_req),
    .clr_pending_i (state_q == ST_LOAD),
    .set_mask_i    (enter_drain),
    .rti_done_i    (rti_done),
    .pending_o     (pending),
    .mask_o        (mask)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc;
    case (state_q)
      ST_IDLE: begin
        if (pending && !mask && !branch_busy) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_PUSH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_PUSH:   state_d = ST_VECTOR;
      ST_VECTOR: begin
        if (mem_ready) begin
          new_pc_d = mem_rdata;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign enter_drain = (state_q == ST_IDLE) && (state_d == ST_DRAIN);

  // Outputs are decoded from state_d so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      new_pc       <= '0;
      stall_fetch  <= 1'b0;
      flush_decode <= 1'b0;
      interrupt    <= 1'b0;
      vec_rd       <= 1'b0;
      vec_addr     <= '0;
      load_pc      <= 1'b0;
      int_ack      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      new_pc       <= new_pc_d;
      stall_fetch  <= state_d inside {ST_DRAIN, ST_PUSH, ST_VECTOR};
      flush_decode <= (state_d == ST_DRAIN);
      interrupt    <= (state_d == ST_PUSH);
      vec_rd       <= (state_d == ST_VECTOR);
      vec_addr     <= (state_d == ST_VECTOR) ? VEC_ADDR : '0;
      load_pc      <= (state_d == ST_LOAD);
      int_ack      <= (state_d == ST_LOAD);
      busy         <= (state_d != ST_IDLE);
    end
  end

endmodule : interrupt_sequencer

// File: tb/tb_interrupt_sequencer.sv
// Directed testbench for interrupt_sequencer. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_interrupt_sequencer;

  localparam int          ADDR_W = 16;
  localparam logic [15:0] VEC    = 16'h1FC0;

  // Expected flag vectors: {busy, stall, flush, interrupt, vec_rd, load_pc, int_ack}
  localparam logic [6:0] E_IDLE  = 7'b0000000;
  localparam logic [6:0] E_DRAIN = 7'b1110000;
  localparam logic [6:0] E_PUSH  = 7'b1101000;
  localparam logic [6:0] E_VECT  = 7'b1100100;
  localparam logic [6:0] E_LOAD  = 7'b1000011;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              int_req, branch_busy, rti_done, mem_ready;
  logic [ADDR_W-1:0] mem_rdata;
  logic              stall_fetch, flush_decode, interrupt, vec_rd;
  logic              load_pc, int_ack, busy;
  logic [ADDR_W-1:0] vec_addr, new_pc;
  logic [6:0]        obs;

  int checks   = 0;
  int failures = 0;

  interrupt_sequencer #(
    .DRAIN_CYCLES (3),
    .ADDR_W       (ADDR_W),
    .VEC_ADDR     (VEC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .int_req      (int_req),
    .branch_busy  (branch_busy),
    .rti_done     (rti_done),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .stall_fetch  (stall_fetch),
    .flush_decode (flush_decode),
    .interrupt    (interrupt),
    .vec_rd       (vec_rd),
    .vec_addr     (vec_addr),
    .load_pc      (load_pc),
    .new_pc       (new_pc),
    .int_ack      (int_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign obs = {busy, stall_fetch, flush_decode, interrupt, vec_rd, load_pc, int_ack};

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [6:0] exp_flags);
    check({tag, "/flags"}, 32'(obs), 32'(exp_flags));
    check({tag, "/vec_addr"}, 32'(vec_addr),
          (exp_flags == E_VECT) ? 32'(VEC) : 32'h0);
  endtask

  // Precondition: the next rising edge moves IDLE -> DRAIN.
  task automatic expect_service(input string tag, input logic [15:0] rdata,
                                input int waits, input logic bb);
    step();
    int_req     = 1'b0;
    rti_done    = 1'b0;
    branch_busy = bb;
    mem_rdata   = rdata;
    mem_ready   = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (d > 0) step();
      check_outs({tag, "/drain"}, E_DRAIN);
    end
    step();
    check_outs({tag, "/push"}, E_PUSH);
    mem_ready = (waits == 0);
    for (int i = 0; i <= waits; i++) begin
      step();
      check_outs({tag, "/vector"}, E_VECT);
      mem_ready = (i >= waits);
    end
    step();
    check_outs({tag, "/load"}, E_LOAD);
    check({tag, "/new_pc"}, 32'(new_pc), 32'(rdata));
    mem_ready   = 1'b0;
    branch_busy = 1'b0;
    step();
    check_outs({tag, "/idle"}, E_IDLE);
    check({tag, "/new_pc_hold"}, 32'(new_pc), 32'(rdata));
  endtask

  task automatic rti_pulse();
    rti_done = 1'b1;
    step();
    rti_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; int_req = 1'b0; branch_busy = 1'b0; rti_done = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) step();
    check_outs("reset", E_IDLE);
    check("reset/new_pc", 32'(new_pc), 32'h0);
    rst_n = 1'b1;
    step();
    check_outs("post_reset", E_IDLE);

    // 1: basic sequence, vector data ready immediately; load_pc 7 edges after pulse
    int_req   = 1'b1;
    mem_ready = 1'b1;
    step();
    int_req = 1'b0;
    check_outs("s1/latched", E_IDLE);
    expect_service("s1", 16'h0040, 0, 1'b0);
    rti_pulse();

    // 2: branch_busy blocks acceptance for 4 cycles; ignored once draining
    int_req     = 1'b1;
    branch_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      int_req = 1'b0;
      check_outs("s2/blocked", E_IDLE);
    end
    branch_busy = 1'b0;
    expect_service("s2", 16'h0A5C, 0, 1'b1);

    // 3: request while masked waits; DRAIN the cycle after rti_done
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_outs("s3/masked", E_IDLE);
      step();
    end
    rti_done = 1'b1;
    expect_service("s3", 16'h3333, 0, 1'b0);

    // 4: rti_done and int_req together -> DRAIN two edges later, mask set again
    rti_done = 1'b1;
    int_req  = 1'b1;
    step();
    rti_done = 1'b0;
    int_req  = 1'b0;
    check_outs("s4/same_cycle", E_IDLE);
    expect_service("s4", 16'h0123, 1, 1'b0);
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_outs("s4/remasked", E_IDLE);
      step();
    end

    // 5: reset during VECTOR with mem_ready low; interrupt is lost
    rti_done = 1'b1;
    step();
    rti_done = 1'b0;
    check_outs("s5/drain", E_DRAIN);
    repeat (2) step();
    step();
    check_outs("s5/push", E_PUSH);
    step();
    check_outs("s5/vector", E_VECT);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_outs("s5/async_reset", E_IDLE);
    check("s5/reset_new_pc", 32'(new_pc), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_outs("s5/abandoned", E_IDLE);
    end
    mem_ready = 1'b0;

    // 6: mem_ready delayed 5 cycles -> vec_rd for 6 cycles (also shows
    // reset cleared the mask, since no rti_done was sent)
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    check_outs("s6/latched", E_IDLE);
    expect_service("s6", 16'hBEEF, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("s6/single_load", E_IDLE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_interrupt_sequencer
